// File: rtl/csr_arb_rr.sv
// N-to-1 round-robin CSR request arbiter with in-order response routing.
// The grant locks under slave backpressure; a routing FIFO steers each response home.
module csr_arb_rr #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIV_W    = 2,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_MASTERS-1:0]               m_req_valid,
    output logic [N_MASTERS-1:0]               m_req_ready,
    input  logic [N_MASTERS-1:0]               m_req_write,
    input  logic [N_MASTERS*ADDR_W-1:0]        m_req_addr,
    input  logic [N_MASTERS*DATA_W-1:0]        m_req_wdata,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]    m_req_wstrb,
    input  logic [N_MASTERS*PRIV_W-1:0]        m_req_priv,
    output logic [N_MASTERS-1:0]               m_rsp_valid,
    input  logic [N_MASTERS-1:0]               m_rsp_ready,
    output logic [DATA_W-1:0]                  m_rsp_rdata,
    output logic                               m_rsp_fault,
    output logic                               m_rsp_side_effect,
    output logic                               s_req_valid,
    output logic                               s_req_write,
    output logic [ADDR_W-1:0]                  s_req_addr,
    output logic [DATA_W-1:0]                  s_req_wdata,
    output logic [DATA_W/8-1:0]                s_req_wstrb,
    output logic [PRIV_W-1:0]                  s_req_priv,
    input  logic                               s_req_ready,
    input  logic                               s_rsp_valid,
    input  logic [DATA_W-1:0]                  s_rsp_rdata,
    input  logic                               s_rsp_fault,
    input  logic                               s_rsp_side_effect,
    output logic                               s_rsp_ready,
    output logic [$clog2(MAX_OUT+1)-1:0]       outstanding,
    output logic                               orphan_err
);

    localparam int unsigned IDX_W  = $clog2(N_MASTERS);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             orphan_q, orphan_d;

    logic [IDX_W-1:0] rr_idx, gnt, route_idx;
    logic [IDX_W:0]   rr_sum;
    logic             rr_found, full, empty, accept, route_vld;
    logic             rsp_hs, bypass, push, pop, orphan;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // First requesting master at or after the round-robin pointer
    always_comb begin : rr_pick
        rr_idx   = rr_ptr_q;
        rr_found = 1'b0;
        rr_sum   = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (rr_sum >= (IDX_W+1)'(N_MASTERS)) begin
                rr_sum = rr_sum - (IDX_W+1)'(N_MASTERS);
            end
            if (!rr_found && m_req_valid[rr_sum[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[IDX_W-1:0];
            end
        end
    end

    assign gnt    = lock_q ? lock_idx_q : rr_idx;
    assign full   = (count_q == CNT_W'(MAX_OUT));
    assign empty  = (count_q == '0);
    assign accept = s_req_valid && s_req_ready;

    // Request forwarding from the granted master
    always_comb begin : req_mux
        s_req_valid = m_req_valid[gnt] && !full;
        m_req_ready = '0;
        m_req_ready[gnt] = s_req_ready && !full;
        s_req_write = 1'b0;
        s_req_addr  = '0;
        s_req_wdata = '0;
        s_req_wstrb = '0;
        s_req_priv  = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (gnt == IDX_W'(i)) begin
                s_req_write = m_req_write[i];
                s_req_addr  = m_req_addr[i*ADDR_W +: ADDR_W];
                s_req_wdata = m_req_wdata[i*DATA_W +: DATA_W];
                s_req_wstrb = m_req_wstrb[i*STRB_W +: STRB_W];
                s_req_priv  = m_req_priv[i*PRIV_W +: PRIV_W];
            end
        end
    end

    // Response steering: FIFO head, or the same-cycle grant when the FIFO is empty
    always_comb begin : rsp_route
        route_vld   = !empty || accept;
        route_idx   = empty ? gnt : fifo_q[rd_ptr_q];
        m_rsp_valid = '0;
        if (route_vld) begin
            m_rsp_valid[route_idx] = s_rsp_valid;
        end
        s_rsp_ready = route_vld ? m_rsp_ready[route_idx] : 1'b1;
        rsp_hs      = s_rsp_valid && s_rsp_ready;
        bypass      = empty && accept && rsp_hs;
        push        = accept && !bypass;
        pop         = rsp_hs && !empty;
        orphan      = s_rsp_valid && !route_vld;
    end

    assign m_rsp_rdata       = s_rsp_rdata;
    assign m_rsp_fault       = s_rsp_fault;
    assign m_rsp_side_effect = s_rsp_side_effect;
    assign outstanding       = count_q;
    assign orphan_err        = orphan_q;

    always_comb begin : next_state
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        orphan_d   = orphan_q || orphan;
        if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = (gnt == IDX_W'(N_MASTERS - 1)) ? '0 : gnt + IDX_W'(1);
        end else if (s_req_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt;
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            orphan_q   <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            orphan_q   <= orphan_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= gnt;
            end
        end
    end

    a_rsp_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(m_rsp_valid));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        s_req_valid && !s_req_ready |=> s_req_valid &&
        $stable({s_req_write, s_req_addr, s_req_wdata, s_req_wstrb, s_req_priv}));

endmodule

// File: tb/tb_csr_arb_rr.sv
// Randomized scoreboard bench for csr_arb_rr: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor pops and compares them.
module tb_csr_arb_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 2;
    localparam int unsigned MO = 4;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = $clog2(MO + 1);

    logic            clk, rst_n;
    logic [N-1:0]    m_req_valid, m_req_ready, m_req_write, m_rsp_valid, m_rsp_ready;
    logic [N*AW-1:0] m_req_addr;
    logic [N*DW-1:0] m_req_wdata;
    logic [N*SW-1:0] m_req_wstrb;
    logic [N*PW-1:0] m_req_priv;
    logic [DW-1:0]   m_rsp_rdata;
    logic            m_rsp_fault, m_rsp_side_effect;
    logic            s_req_valid, s_req_write, s_req_ready;
    logic [AW-1:0]   s_req_addr;
    logic [DW-1:0]   s_req_wdata;
    logic [SW-1:0]   s_req_wstrb;
    logic [PW-1:0]   s_req_priv;
    logic            s_rsp_valid, s_rsp_fault, s_rsp_side_effect, s_rsp_ready;
    logic [DW-1:0]   s_rsp_rdata;
    logic [CW-1:0]   outstanding;
    logic            orphan_err;

    csr_arb_rr #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .PRIV_W(PW), .MAX_OUT(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_req_priv(m_req_priv), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_fault(m_rsp_fault),
        .m_rsp_side_effect(m_rsp_side_effect),
        .s_req_valid(s_req_valid), .s_req_write(s_req_write), .s_req_addr(s_req_addr),
        .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb), .s_req_priv(s_req_priv),
        .s_req_ready(s_req_ready), .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_fault(s_rsp_fault), .s_rsp_side_effect(s_rsp_side_effect),
        .s_rsp_ready(s_rsp_ready), .outstanding(outstanding), .orphan_err(orphan_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          srv;
        logic [N-1:0]  mrr;
        logic [N-1:0]  mrv;
        logic          srr_chk;
        logic          srr;
        logic [CW-1:0] out;
        logic          orph;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [PW-1:0] priv;
        logic [DW-1:0] rdata;
        logic          flt;
        logic          se;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_pass = 0;
    int   gcnt [N];
    int   p_req, p_sr, p_rsp, p_spec, p_mrr;

    // Reference model: pointer, lock, and an in-order queue of master ids
    int     mdl_ptr, mdl_lkg;
    bit     mdl_lk, mdl_orph;
    int     mdl_fq[$];
    logic [N-1:0] last_mrr;
    bit     last_acc, last_rhs;
    int     slv_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit rnd(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic step(input bit rst);
        exp_t e;
        int   g, t;
        bit   found, full, acc, tv, rhs, byp;
        @(posedge clk);
        #1;
        if (rst) begin
            rst_n = 1'b0;
            m_req_valid = '0;
            m_rsp_ready = '0;
            s_req_ready = 1'b0;
            s_rsp_valid = 1'b0;
            mdl_ptr = 0; mdl_lk = 0; mdl_lkg = 0; mdl_orph = 0;
            mdl_fq.delete();
        end else begin
            rst_n = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (m_req_valid[i] && last_mrr[i]) m_req_valid[i] = 1'b0;
                if (!m_req_valid[i] && rnd(p_req)) begin
                    m_req_valid[i] = 1'b1;
                    m_req_write[i] = 1'($urandom);
                    m_req_addr[i*AW +: AW]  = $urandom;
                    m_req_wdata[i*DW +: DW] = $urandom;
                    m_req_wstrb[i*SW +: SW] = SW'($urandom);
                    m_req_priv[i*PW +: PW]  = PW'($urandom);
                end
                m_rsp_ready[i] = rnd(p_mrr);
            end
            if (last_acc) slv_pend++;
            if (s_rsp_valid && last_rhs) begin
                s_rsp_valid = 1'b0;
                if (slv_pend > 0) slv_pend--;
            end
            if (!s_rsp_valid && ((slv_pend > 0 && rnd(p_rsp)) || rnd(p_spec))) begin
                s_rsp_valid       = 1'b1;
                s_rsp_rdata       = $urandom;
                s_rsp_fault       = 1'($urandom);
                s_rsp_side_effect = 1'($urandom);
            end
            s_req_ready = rnd(p_sr);
        end

        g = mdl_ptr;
        found = 0;
        if (mdl_lk) g = mdl_lkg;
        else begin
            for (int k = 0; k < N; k++) begin
                if (!found && m_req_valid[(mdl_ptr + k) % N]) begin
                    g = (mdl_ptr + k) % N;
                    found = 1;
                end
            end
        end
        full  = (mdl_fq.size() == MO);
        e.srv = m_req_valid[g] && !full;
        acc   = e.srv && s_req_ready;
        e.mrr = '0;
        e.mrr[g] = s_req_ready && !full;
        tv = 0;
        t  = 0;
        if (mdl_fq.size() > 0) begin
            tv = 1; t = mdl_fq[0];
        end else if (acc) begin
            tv = 1; t = g;
        end
        e.srr     = tv ? m_rsp_ready[t] : 1'b1;
        e.srr_chk = s_rsp_valid;
        e.mrv     = '0;
        if (tv) e.mrv[t] = s_rsp_valid;
        rhs   = s_rsp_valid && e.srr;
        e.out  = CW'(mdl_fq.size());
        e.orph = mdl_orph;
        e.wr    = m_req_write[g];
        e.addr  = m_req_addr[g*AW +: AW];
        e.wdata = m_req_wdata[g*DW +: DW];
        e.wstrb = m_req_wstrb[g*SW +: SW];
        e.priv  = m_req_priv[g*PW +: PW];
        e.rdata = s_rsp_rdata;
        e.flt   = s_rsp_fault;
        e.se    = s_rsp_side_effect;
        exp_q.push_back(e);
        last_mrr = e.mrr;
        last_acc = acc;
        last_rhs = rhs;

        if (!rst) begin
            if (e.srv && !s_req_ready) begin
                mdl_lk = 1; mdl_lkg = g;
            end
            if (acc) begin
                mdl_lk = 0;
                mdl_ptr = (g + 1) % N;
            end
            byp = acc && (mdl_fq.size() == 0) && rhs;
            if (s_rsp_valid && !tv) mdl_orph = 1;
            if (rhs && mdl_fq.size() > 0) void'(mdl_fq.pop_front());
            if (acc && !byp) mdl_fq.push_back(g);
        end
    endtask

    // Monitor: compares each cycle's DUT outputs against the queued prediction
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("s_req_valid", 64'(s_req_valid), 64'(cur.srv));
            chk("m_req_ready", 64'(m_req_ready), 64'(cur.mrr));
            chk("m_rsp_valid", 64'(m_rsp_valid), 64'(cur.mrv));
            chk("outstanding", 64'(outstanding), 64'(cur.out));
            chk("orphan_err", 64'(orphan_err), 64'(cur.orph));
            if (cur.srr_chk) chk("s_rsp_ready", 64'(s_rsp_ready), 64'(cur.srr));
            if (cur.srv) begin
                chk("s_req_write", 64'(s_req_write), 64'(cur.wr));
                chk("s_req_addr", 64'(s_req_addr), 64'(cur.addr));
                chk("s_req_wdata", 64'(s_req_wdata), 64'(cur.wdata));
                chk("s_req_wstrb", 64'(s_req_wstrb), 64'(cur.wstrb));
                chk("s_req_priv", 64'(s_req_priv), 64'(cur.priv));
            end
            if (cur.mrv != '0) begin
                chk("m_rsp_rdata", 64'(m_rsp_rdata), 64'(cur.rdata));
                chk("m_rsp_fault", 64'(m_rsp_fault), 64'(cur.flt));
                chk("m_rsp_side_effect", 64'(m_rsp_side_effect), 64'(cur.se));
            end
            if (s_req_valid && s_req_ready) begin
                for (int i = 0; i < N; i++) if (m_req_ready[i]) gcnt[i]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        m_req_valid = '0; m_req_write = '0; m_req_addr = '0; m_req_wdata = '0;
        m_req_wstrb = '0; m_req_priv = '0; m_rsp_ready = '0;
        s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_rdata = '0;
        s_rsp_fault = 1'b0; s_rsp_side_effect = 1'b0;
        mdl_ptr = 0; mdl_lkg = 0; mdl_lk = 0; mdl_orph = 0;
        last_mrr = '0; last_acc = 0; last_rhs = 0; slv_pend = 0;
        p_req = 0; p_sr = 0; p_rsp = 0; p_spec = 0; p_mrr = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        repeat (3) step(1'b1);

        // Saturated fairness: every master always requesting, slave always ready
        p_req = 100; p_sr = 100; p_rsp = 100; p_spec = 0; p_mrr = 100;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        repeat (40) step(1'b0);
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("fair_grants_m%0d", i), 64'(gcnt[i]), 64'd10);

        // Heavy slave request backpressure exercises the grant lock
        p_req = 60; p_sr = 25; p_rsp = 60; p_spec = 0; p_mrr = 80;
        repeat (600) step(1'b0);

        // Slow responses drive the routing FIFO to full
        p_req = 80; p_sr = 90; p_rsp = 5; p_spec = 0; p_mrr = 50;
        repeat (600) step(1'b0);

        // Reset with requests in flight; late responses become orphans
        repeat (2) step(1'b1);
        p_req = 30; p_sr = 80; p_rsp = 50; p_spec = 25; p_mrr = 60;
        repeat (800) step(1'b0);

        repeat (2) step(1'b1);
        p_req = 50; p_sr = 60; p_rsp = 40; p_spec = 3; p_mrr = 70;
        repeat (800) step(1'b0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
